// File: rtl/memref_loader_pkg.sv
// Shared types and constants for the memref stream loader.
// Optional out-of-bounds read checking is enabled with MEMREF_LOADER_OOB_CHECK_EN.
package memref_loader_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        SERVE = 2'd2
    } loader_state_e;

    // The kernel expects read data one cycle after its strobe.
    localparam int HIR_RD_LATENCY = 1;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/memref_loader_ram.sv
// Simple dual-port buffer: one write port, one registered read port.
// The array has no reset; only the read output register is cleared.
module memref_loader_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Read register holds its value unless a read is strobed.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read output register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/memref_stream_loader.sv
// Loads a frame from a valid/ready stream into a buffer, pulses tstart, then
// serves the kernel's memref reads until FRAME_LEN reads have been counted.
// Handshake: a stream word transfers on a rising edge where s_valid and s_ready
// are both high; s_ready is high only while filling and does not depend on s_valid.
// Define MEMREF_LOADER_OOB_CHECK_EN to add the sticky oob_err output.
module memref_stream_loader
    import memref_loader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int FRAME_LEN = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic [ADDR_W-1:0]      v0_addr,
    input  logic                   v0_rd_en,
    output logic [DATA_W-1:0]      v0_rd_data,
    output logic                   tstart,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef MEMREF_LOADER_OOB_CHECK_EN
    ,
    output logic                   oob_err
`endif
);

    if (FRAME_LEN < 1 || FRAME_LEN > 2**ADDR_W) begin : g_bad_frame_len
        $error("FRAME_LEN must be in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(FRAME_LEN - 1);

    loader_state_e          state_q, state_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]        rd_cnt_q, rd_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   tstart_q, tstart_d;
    logic                   wr_en;

    // Reset wins over a same-cycle handshake, so the word is dropped.
    assign s_ready = (state_q == FILL);
    assign wr_en   = s_ready && s_valid && rst_n;

    // Next-state and counter logic for the fill/start/serve sequence.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            FILL: begin
                if (s_valid) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if ({1'b0, wr_ptr_q} == LAST_IDX) begin
                        wr_ptr_d = '0;
                        state_d  = START;
                    end
                end
            end
            START: begin
                state_d = SERVE;
            end
            SERVE: begin
                if (v0_rd_en) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_cnt_d    = '0;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = FILL;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        tstart_d = (state_d == START);
    end

    // State, counters and the registered start pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            frame_cnt_q <= '0;
            tstart_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            tstart_q    <= tstart_d;
        end
    end

    assign tstart    = tstart_q;
    assign busy      = (state_q != FILL);
    assign frame_cnt = frame_cnt_q;

    memref_loader_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (s_data),
        .rd_en   (v0_rd_en),
        .rd_addr (v0_addr),
        .rd_data (v0_rd_data)
    );

`ifdef MEMREF_LOADER_OOB_CHECK_EN
    localparam logic [ADDR_W:0] FRAME_LEN_X = (ADDR_W+1)'(FRAME_LEN);

    logic oob_err_q, oob_err_d;
    logic oob_hit;

    // A read is out of bounds past the frame or outside the serve window.
    always_comb begin
        oob_hit   = v0_rd_en && (({1'b0, v0_addr} >= FRAME_LEN_X) || (state_q != SERVE));
        oob_err_d = oob_err_q | oob_hit;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oob_err_q <= 1'b0;
        end else begin
            oob_err_q <= oob_err_d;
        end
    end

`ifndef SYNTHESIS
    // Report each offending read in simulation.
    always_ff @(posedge clk) begin
        if (rst_n && oob_hit) begin
            $error("memref_stream_loader: out-of-bounds read addr=%0d state=%s",
                   v0_addr, state_q.name());
        end
    end
`endif

    assign oob_err = oob_err_q;
`endif

endmodule

// File: tb/tb_memref_stream_loader.sv
// Directed bench for memref_stream_loader: a 256-word instance and a 4-word instance.
module tb_memref_stream_loader;

    logic        clk;
    logic        rst_n;

    // 256-word instance
    logic        s_valid, s_ready, tstart, busy, v0_rd_en;
    logic [31:0] s_data, v0_rd_data;
    logic [7:0]  v0_addr;
    logic [15:0] frame_cnt;

    // 4-word instance
    logic        s_valid4, s_ready4, tstart4, busy4, v0_rd_en4;
    logic [31:0] s_data4, v0_rd_data4;
    logic [7:0]  v0_addr4;
    logic [15:0] frame_cnt4;

    int checks;
    int errors;
    int tstart_cnt;

`ifdef MEMREF_LOADER_OOB_CHECK_EN
    logic        oob_err, oob_err4, oob_err16;
    logic        s_valid16, s_ready16, tstart16, busy16, v0_rd_en16;
    logic [31:0] s_data16, v0_rd_data16;
    logic [7:0]  v0_addr16;
    logic [15:0] frame_cnt16;
`endif

    memref_stream_loader #(.DATA_W(32), .ADDR_W(8), .FRAME_LEN(256)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .v0_addr(v0_addr), .v0_rd_en(v0_rd_en), .v0_rd_data(v0_rd_data),
        .tstart(tstart), .busy(busy), .frame_cnt(frame_cnt)
`ifdef MEMREF_LOADER_OOB_CHECK_EN
        , .oob_err(oob_err)
`endif
    );

    memref_stream_loader #(.DATA_W(32), .ADDR_W(8), .FRAME_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
        .v0_addr(v0_addr4), .v0_rd_en(v0_rd_en4), .v0_rd_data(v0_rd_data4),
        .tstart(tstart4), .busy(busy4), .frame_cnt(frame_cnt4)
`ifdef MEMREF_LOADER_OOB_CHECK_EN
        , .oob_err(oob_err4)
`endif
    );

`ifdef MEMREF_LOADER_OOB_CHECK_EN
    memref_stream_loader #(.DATA_W(32), .ADDR_W(8), .FRAME_LEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid16), .s_ready(s_ready16), .s_data(s_data16),
        .v0_addr(v0_addr16), .v0_rd_en(v0_rd_en16), .v0_rd_data(v0_rd_data16),
        .tstart(tstart16), .busy(busy16), .frame_cnt(frame_cnt16), .oob_err(oob_err16)
    );
`endif

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses of the 256-word instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (tstart === 1'b1) tstart_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
        checks++; if (tstart !== 1'b0) begin errors++; $display("FAIL reset_tstart got %b exp 0", tstart); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (v0_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", v0_rd_data); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
        checks++; if (s_ready4 !== 1'b1) begin errors++; $display("FAIL reset_s_ready4 got %b exp 1", s_ready4); end
    endtask

    task automatic test_fill_seq;
        int t0;
        t0 = tstart_cnt;
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            if (s_ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL fill_ready word %0d got %b exp 1", i, s_ready);
            end
            tick();
        end
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_fall got %b exp 0", s_ready); end
        checks++; if (tstart !== 1'b1) begin errors++; $display("FAIL fill_tstart got %b exp 1", tstart); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b exp 1", busy); end
        tick();
        checks++; if (tstart !== 1'b0) begin errors++; $display("FAIL fill_tstart_end got %b exp 0", tstart); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL serve_busy got %b exp 1", busy); end
        checks++; if (tstart_cnt - t0 !== 1) begin errors++; $display("FAIL fill_tstart_cnt got %0d exp 1", tstart_cnt - t0); end
    endtask

    task automatic test_serve_seq(input logic [31:0] base, input logic [15:0] exp_frames);
        for (int i = 0; i < 256; i++) begin
            v0_rd_en = 1'b1;
            v0_addr  = 8'(i);
            if (i == 255) begin
                checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL serve_ready_early got %b exp 0", s_ready); end
            end
            tick();
            checks++;
            if (v0_rd_data !== base + 32'(i)) begin
                errors++;
                $display("FAIL serve_data addr %0d got %h exp %h", i, v0_rd_data, base + 32'(i));
            end
        end
        v0_rd_en = 1'b0;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL serve_done_ready got %b exp 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL serve_done_busy got %b exp 0", busy); end
        checks++; if (frame_cnt !== exp_frames) begin errors++; $display("FAIL serve_frame_cnt got %0d exp %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_random_valid;
        int acc;
        int t0;
        int iter;
        acc  = 0;
        iter = 0;
        t0   = tstart_cnt;
        while (acc < 256 && iter < 5000) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 32'hA500_0000 + 32'(acc);
            if (s_valid && s_ready) acc++;
            tick();
            iter++;
        end
        s_valid = 1'b0;
        checks++; if (acc != 256) begin errors++; $display("FAIL rand_timeout accepted %0d exp 256", acc); end
        checks++; if (tstart !== 1'b1) begin errors++; $display("FAIL rand_tstart got %b exp 1", tstart); end
        tick();
        checks++; if (tstart_cnt - t0 !== 1) begin errors++; $display("FAIL rand_tstart_cnt got %0d exp 1", tstart_cnt - t0); end
        test_serve_seq(32'hA500_0000, 16'd2);
    endtask

    task automatic test_frame_len4;
        logic [31:0] words [4];
        logic [31:0] got;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) words[i] = 32'(10 * (i + 1) + 40 * f);
            for (int i = 0; i < 4; i++) begin
                s_valid4 = 1'b1;
                s_data4  = words[i];
                tick();
            end
            s_valid4 = 1'b0;
            checks++; if (tstart4 !== 1'b1) begin errors++; $display("FAIL len4_tstart frame %0d got %b exp 1", f, tstart4); end
            tick();
            // reads 3,0,1,2
            for (int k = 0; k < 4; k++) begin
                v0_rd_en4 = 1'b1;
                v0_addr4  = 8'((k + 3) % 4);
                checks++; if (s_ready4 !== 1'b0) begin errors++; $display("FAIL len4_ready_serve k %0d got %b exp 0", k, s_ready4); end
                tick();
                got = v0_rd_data4;
                checks++;
                if (got !== words[(k + 3) % 4]) begin
                    errors++;
                    $display("FAIL len4_data frame %0d addr %0d got %0d exp %0d", f, (k + 3) % 4, got, words[(k + 3) % 4]);
                end
            end
            v0_rd_en4 = 1'b0;
            checks++; if (s_ready4 !== 1'b1) begin errors++; $display("FAIL len4_back_to_fill got %b exp 1", s_ready4); end
            checks++; if (frame_cnt4 !== 16'(f + 1)) begin errors++; $display("FAIL len4_frame_cnt got %0d exp %0d", frame_cnt4, f + 1); end
        end
    endtask

    task automatic test_reset_mid_serve;
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(3 * i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            v0_rd_en = 1'b1;
            v0_addr  = 8'(i);
            tick();
        end
        v0_rd_en = 1'b0;
        // Handshake presented during reset must be ignored.
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        tick();
        rst_n   = 1'b1;
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        checks++; if (tstart !== 1'b0) begin errors++; $display("FAIL rst_mid_tstart got %b exp 0", tstart); end
        checks++; if (v0_rd_data !== 32'd0) begin errors++; $display("FAIL rst_mid_rd_data got %h exp 0", v0_rd_data); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_frame_cnt got %0d exp 0", frame_cnt); end
        // A read in FILL returns stored data and is not counted.
        v0_rd_en = 1'b1;
        v0_addr  = 8'd5;
        tick();
        v0_rd_en = 1'b0;
        checks++; if (v0_rd_data !== 32'd15) begin errors++; $display("FAIL fill_read got %0d exp 15", v0_rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_read_busy got %b exp 0", busy); end
        // Next frame starts at address 0.
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h100 + 32'(i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        test_serve_seq(32'h100, 16'd1);
    endtask

`ifdef MEMREF_LOADER_OOB_CHECK_EN
    task automatic test_oob;
        checks++; if (oob_err16 !== 1'b0) begin errors++; $display("FAIL oob_initial got %b exp 0", oob_err16); end
        for (int i = 0; i < 16; i++) begin
            s_valid16 = 1'b1;
            s_data16  = 32'(i);
            tick();
        end
        s_valid16 = 1'b0;
        tick();
        v0_rd_en16 = 1'b1;
        v0_addr16  = 8'd20;
        tick();
        v0_rd_en16 = 1'b0;
        checks++; if (oob_err16 !== 1'b1) begin errors++; $display("FAIL oob_set got %b exp 1", oob_err16); end
        tick();
        tick();
        checks++; if (oob_err16 !== 1'b1) begin errors++; $display("FAIL oob_sticky got %b exp 1", oob_err16); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (oob_err16 !== 1'b0) begin errors++; $display("FAIL oob_reset got %b exp 0", oob_err16); end
        v0_rd_en16 = 1'b1;
        v0_addr16  = 8'd2;
        tick();
        v0_rd_en16 = 1'b0;
        checks++; if (oob_err16 !== 1'b1) begin errors++; $display("FAIL oob_fill_read got %b exp 1", oob_err16); end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        tstart_cnt = 0;
        rst_n      = 1'b0;
        s_valid    = 1'b0; s_data  = '0; v0_addr  = '0; v0_rd_en  = 1'b0;
        s_valid4   = 1'b0; s_data4 = '0; v0_addr4 = '0; v0_rd_en4 = 1'b0;
`ifdef MEMREF_LOADER_OOB_CHECK_EN
        s_valid16 = 1'b0; s_data16 = '0; v0_addr16 = '0; v0_rd_en16 = 1'b0;
`endif
        test_reset();
        test_fill_seq();
        test_serve_seq(32'd0, 16'd1);
        test_random_valid();
        test_frame_len4();
        test_reset_mid_serve();
`ifdef MEMREF_LOADER_OOB_CHECK_EN
        test_oob();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
